// File: rtl/motion_pwm_driver.sv
// Two-wheel motor driver: decodes motion commands into per-wheel duty/direction targets,
// ramps duty on a prescaled tick, inserts dead-time before reversal, and emits registered PWM.
module motion_pwm_driver #(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned DUTY_MAX  = 200,
    parameter int unsigned TURN_DUTY = 120,
    parameter int unsigned RAMP_DIV  = 1000,
    parameter int unsigned DEAD_CYC  = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic move_forward,
    input  logic move_backward,
    input  logic turn_left,
    input  logic turn_right,
    output logic left_pwm,
    output logic left_dir,
    output logic right_pwm,
    output logic right_dir,
    output logic moving,
    output logic cmd_fault
);
    localparam int unsigned PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DEAD_W  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX_V  = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] TURN_DUTY_V = PWM_BITS'(TURN_DUTY);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} wheel_state_e;

    // Index 0 = left wheel, 1 = right wheel throughout.
    logic [1:0][PWM_BITS-1:0] tgt_duty_q, tgt_duty_d;
    logic [1:0]               tgt_dir_q, tgt_dir_d;
    logic [1:0][PWM_BITS-1:0] duty_q, duty_d;
    logic [1:0]               dir_q, dir_d;
    wheel_state_e             state_q [2];
    wheel_state_e             state_d [2];
    logic [DEAD_W-1:0]        dead_cnt_q [2];
    logic [DEAD_W-1:0]        dead_cnt_d [2];
    logic [PRESC_W-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0]      cnt_q, cnt_d;
    logic [1:0]               pwm_q, pwm_d;
    logic                     moving_q, moving_d;
    logic                     cmd_fault_q, cmd_fault_d;
    logic                     conflict;
    logic                     tick;

    always_comb begin
        conflict    = (move_forward & move_backward) | (turn_left & turn_right);
        cmd_fault_d = conflict;
        tgt_duty_d  = '0;
        tgt_dir_d   = tgt_dir_q;
        if (enable && !conflict) begin
            if (move_forward || move_backward) begin
                // Straight or arc: inner wheel of an arc slows to TURN_DUTY.
                tgt_dir_d     = {move_forward, move_forward};
                tgt_duty_d[0] = turn_left  ? TURN_DUTY_V : DUTY_MAX_V;
                tgt_duty_d[1] = turn_right ? TURN_DUTY_V : DUTY_MAX_V;
            end else if (turn_left || turn_right) begin
                tgt_dir_d     = {turn_left, turn_right};
                tgt_duty_d[0] = TURN_DUTY_V;
                tgt_duty_d[1] = TURN_DUTY_V;
            end
        end
    end

    always_comb begin
        tick    = (presc_q == PRESC_W'(RAMP_DIV - 1));
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        cnt_d   = cnt_q + PWM_BITS'(1);
        pwm_d[0] = (cnt_q < duty_q[0]);
        pwm_d[1] = (cnt_q < duty_q[1]);
        moving_d = (duty_q != '0);
        duty_d  = duty_q;
        dir_d   = dir_q;
        for (int unsigned w = 0; w < 2; w++) begin
            state_d[w]    = state_q[w];
            dead_cnt_d[w] = dead_cnt_q[w];
            if (!enable) begin
                state_d[w] = IDLE;
                duty_d[w]  = '0;
            end else begin
                case (state_q[w])
                    IDLE: begin
                        duty_d[w] = '0;
                        if (tgt_duty_q[w] != '0) begin
                            if (tgt_dir_q[w] == dir_q[w]) begin
                                state_d[w] = RUN;
                            end else begin
                                state_d[w]    = DEAD;
                                dead_cnt_d[w] = '0;
                            end
                        end
                    end
                    RUN: begin
                        // Reversal is checked before ramping so it wins over a coincident tick.
                        if (tgt_dir_q[w] != dir_q[w]) begin
                            duty_d[w]     = '0;
                            state_d[w]    = DEAD;
                            dead_cnt_d[w] = '0;
                        end else if (tgt_duty_q[w] == '0) begin
                            duty_d[w]  = '0;
                            state_d[w] = IDLE;
                        end else if (tgt_duty_q[w] < duty_q[w]) begin
                            duty_d[w] = tgt_duty_q[w];
                        end else if (tick && (duty_q[w] < tgt_duty_q[w])) begin
                            duty_d[w] = duty_q[w] + PWM_BITS'(1);
                        end
                    end
                    DEAD: begin
                        duty_d[w] = '0;
                        if (dead_cnt_q[w] == DEAD_W'(DEAD_CYC - 1)) begin
                            dir_d[w]   = tgt_dir_q[w];
                            state_d[w] = (tgt_duty_q[w] != '0) ? RUN : IDLE;
                        end else begin
                            dead_cnt_d[w] = dead_cnt_q[w] + DEAD_W'(1);
                        end
                    end
                    default: begin
                        duty_d[w]  = '0;
                        state_d[w] = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tgt_duty_q  <= '0;
            tgt_dir_q   <= '1;
            duty_q      <= '0;
            dir_q       <= '1;
            presc_q     <= '0;
            cnt_q       <= '0;
            pwm_q       <= '0;
            moving_q    <= 1'b0;
            cmd_fault_q <= 1'b0;
            for (int unsigned w = 0; w < 2; w++) begin
                state_q[w]    <= IDLE;
                dead_cnt_q[w] <= '0;
            end
        end else begin
            tgt_duty_q  <= tgt_duty_d;
            tgt_dir_q   <= tgt_dir_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            moving_q    <= moving_d;
            cmd_fault_q <= cmd_fault_d;
            for (int unsigned w = 0; w < 2; w++) begin
                state_q[w]    <= state_d[w];
                dead_cnt_q[w] <= dead_cnt_d[w];
            end
        end
    end

    assign left_pwm  = pwm_q[0];
    assign right_pwm = pwm_q[1];
    assign left_dir  = dir_q[0];
    assign right_dir = dir_q[1];
    assign moving    = moving_q;
    assign cmd_fault = cmd_fault_q;
endmodule

// File: tb/tb_motion_pwm_driver.sv
// Directed and randomized bench for motion_pwm_driver against a cycle-level behavioural model.
module tb_motion_pwm_driver;
    localparam int PB = 4, DM = 12, TD = 6, RD = 2, DC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0, enable = 1'b1;
    logic mf = 1'b0, mb = 1'b0, tl = 1'b0, tr = 1'b0;
    logic left_pwm, left_dir, right_pwm, right_dir, moving, cmd_fault;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state (index 0 = left, 1 = right)
    int m_tgt_duty [2];
    int m_tgt_dir  [2];
    int m_duty     [2];
    int m_dir      [2];
    int m_run      [2];
    int m_dead     [2];
    int m_pwm      [2];
    int m_fault, m_presc, m_cnt, m_moving;

    motion_pwm_driver #(
        .PWM_BITS(PB), .DUTY_MAX(DM), .TURN_DUTY(TD), .RAMP_DIV(RD), .DEAD_CYC(DC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .move_forward(mf), .move_backward(mb), .turn_left(tl), .turn_right(tr),
        .left_pwm(left_pwm), .left_dir(left_dir), .right_pwm(right_pwm), .right_dir(right_dir),
        .moving(moving), .cmd_fault(cmd_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present before that edge.
    task automatic model_step();
        int tick;
        if (!rst) begin
            for (int w = 0; w < 2; w++) begin
                m_tgt_duty[w] = 0; m_tgt_dir[w] = 1; m_duty[w] = 0; m_dir[w] = 1;
                m_run[w] = 0; m_dead[w] = 0; m_pwm[w] = 0;
            end
            m_fault = 0; m_presc = 0; m_cnt = 0; m_moving = 0;
            return;
        end
        tick = (m_presc == RD - 1) ? 1 : 0;
        m_moving = (m_duty[0] != 0 || m_duty[1] != 0) ? 1 : 0;
        for (int w = 0; w < 2; w++) begin
            m_pwm[w] = (m_cnt < m_duty[w]) ? 1 : 0;
            if (!enable) begin
                m_duty[w] = 0; m_run[w] = 0; m_dead[w] = 0;
            end else if (m_dead[w] > 0) begin
                m_duty[w] = 0;
                if (m_dead[w] == 1) begin
                    m_dead[w] = 0;
                    m_dir[w]  = m_tgt_dir[w];
                    m_run[w]  = (m_tgt_duty[w] != 0) ? 1 : 0;
                end else begin
                    m_dead[w]--;
                end
            end else if (m_tgt_duty[w] == 0) begin
                m_duty[w] = 0; m_run[w] = 0;
            end else if (m_tgt_dir[w] != m_dir[w]) begin
                m_duty[w] = 0; m_run[w] = 0; m_dead[w] = DC;
            end else if (m_run[w] == 0) begin
                m_run[w] = 1;
            end else if (m_tgt_duty[w] < m_duty[w]) begin
                m_duty[w] = m_tgt_duty[w];
            end else if (tick == 1 && m_duty[w] < m_tgt_duty[w]) begin
                m_duty[w]++;
            end
        end
        m_presc = (tick == 1) ? 0 : m_presc + 1;
        m_cnt   = (m_cnt + 1) % (1 << PB);
        m_fault = ((mf && mb) || (tl && tr)) ? 1 : 0;
        if (!enable || m_fault == 1 || !(mf || mb || tl || tr)) begin
            m_tgt_duty[0] = 0; m_tgt_duty[1] = 0;
        end else if (mf || mb) begin
            m_tgt_dir[0] = mf ? 1 : 0; m_tgt_dir[1] = mf ? 1 : 0;
            m_tgt_duty[0] = tl ? TD : DM;
            m_tgt_duty[1] = tr ? TD : DM;
        end else begin
            m_tgt_dir[0] = tr ? 1 : 0; m_tgt_dir[1] = tl ? 1 : 0;
            m_tgt_duty[0] = TD; m_tgt_duty[1] = TD;
        end
    endtask

    task automatic cycle(input string tag);
        logic [5:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp = {m_pwm[0][0], m_dir[0][0], m_pwm[1][0], m_dir[1][0], m_moving[0], m_fault[0]};
        check(tag, {26'd0, left_pwm, left_dir, right_pwm, right_dir, moving, cmd_fault}, {26'd0, exp});
    endtask

    task automatic cmd(input logic f, input logic b, input logic l, input logic r);
        mf = f; mb = b; tl = l; tr = r;
    endtask

    initial begin
        int hl, hr, k, segs;
        // Reset held with a forward command present
        cmd(1, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle("reset_model");
            check("reset_out", {26'd0, left_pwm, left_dir, right_pwm, right_dir, moving, cmd_fault},
                  32'b010100);
        end
        rst = 1'b1;

        // Ramp to full duty, then measure one PWM period
        for (int i = 0; i < 40; i++) cycle("ramp_fwd");
        hl = 0; hr = 0;
        for (int i = 0; i < 16; i++) begin
            cycle("pwm_window");
            hl += int'(left_pwm); hr += int'(right_pwm);
        end
        check("left_high_count", hl, 12);
        check("right_high_count", hr, 12);

        // Reversal: dead-time before direction flips
        cmd(0, 1, 0, 0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle("reverse");
            if (left_dir == 1'b0) begin k = i; break; end
        end
        check("reverse_dir_latency", k, 5);
        for (int i = 0; i < 40; i++) cycle("ramp_bwd");

        // Spin left, then forward arc right
        cmd(0, 0, 1, 0);
        for (int i = 0; i < 40; i++) cycle("spin_left");
        check("spin_left_dir", {30'd0, left_dir, right_dir}, 32'b01);
        cmd(1, 0, 0, 1);
        for (int i = 0; i < 40; i++) cycle("arc_right");
        check("arc_right_dir", {30'd0, left_dir, right_dir}, 32'b11);

        // Conflict pulse
        cmd(1, 1, 0, 0);
        cycle("conflict");
        check("conflict_fault", {31'd0, cmd_fault}, 32'd1);
        cmd(1, 0, 0, 0);
        cycle("conflict_after");
        check("conflict_fault_clear", {31'd0, cmd_fault}, 32'd0);
        for (int i = 0; i < 10; i++) cycle("post_conflict");

        // Disable during dead-time
        cmd(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle("into_dead");
        enable = 1'b0;
        for (int i = 0; i < 20; i++) cycle("disabled");
        check("disabled_moving", {31'd0, moving}, 32'd0);
        check("disabled_dir_held", {30'd0, left_dir, right_dir}, 32'b11);
        enable = 1'b1;

        // Reset mid-ramp
        for (int i = 0; i < 12; i++) cycle("reramp");
        rst = 1'b0;
        cycle("mid_reset");
        check("mid_reset_out", {26'd0, left_pwm, left_dir, right_pwm, right_dir, moving, cmd_fault},
              32'b010100);
        rst = 1'b1;

        // Randomized segments
        segs = 0;
        while (segs < 60) begin
            cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) cmd(1'($urandom), 1'b0, 1'b0, 1'b0);
            enable = ($urandom_range(0, 7) != 0);
            rst    = ($urandom_range(0, 29) != 0);
            k = (rst == 1'b0) ? 1 : int'($urandom_range(1, 30));
            for (int i = 0; i < k; i++) begin
                cycle("random");
                rst = 1'b1;
            end
            segs++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
